// File: rtl/ifu_ram_resp.sv
// ifu_ram_resp: instruction-fetch RAM responder reading 64-bit doublewords from a synchronous SRAM
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   ifu_ram_cen_i    one-cycle fetch request strobe (honoured only when idle)
//   ifu_ram_addr_i   byte address of the fetch, sampled at acceptance
//   ifu_ram_size_i   access size, ignored
//   ifu_ram_data_o   aligned doubleword, held until the next capture
//   ifu_ram_valid_o  one-cycle response strobe
//   ifu_ram_err_o    address out of range, qualified by valid
//   inv_i            line buffer invalidate (fence.i)
//   sram_cen_o       SRAM read enable, one pulse per in-range miss
//   sram_addr_o      SRAM word index
//   sram_rdata_i     SRAM read data, valid the cycle after sram_cen_o
//
// Optional feature: define IRAM_LINE_BUF_EN for a one-entry line buffer
// that answers repeated fetches of the same doubleword one cycle after
// acceptance without touching the SRAM.
module ifu_ram_resp #(
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_LOG2  = 16,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifu_ram_cen_i,
  input  logic [63:0]           ifu_ram_addr_i,
  input  logic [2:0]            ifu_ram_size_i,
  output logic [63:0]           ifu_ram_data_o,
  output logic                  ifu_ram_valid_o,
  output logic                  ifu_ram_err_o,
  input  logic                  inv_i,
  output logic                  sram_cen_o,
  output logic [DEPTH_LOG2-1:0] sram_addr_o,
  input  logic [63:0]           sram_rdata_i
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WT, RSP} state_e;
  state_e                state_q, state_d;
  logic [63:0]           off;
  logic                  in_range, hit, accept;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  inr_q, inr_d;
  logic [63:0]           data_q, data_d, buf_data;
  logic                  err_q, err_d;
  logic                  valid_q, valid_d;
  logic                  sram_cen_q, sram_cen_d;
  logic [3:0]            cnt_q, cnt_d;
  assign off      = ifu_ram_addr_i - BASE_ADDR;
  // Lower bound checked directly; an in-range offset has no bits above the SRAM span.
  assign in_range = (ifu_ram_addr_i >= BASE_ADDR) && (off[63:DEPTH_LOG2+3] == '0);
  assign accept   = (state_q == IDLE) && ifu_ram_cen_i;
`ifdef IRAM_LINE_BUF_EN
  logic [60:0] tag_q, buf_tag_q;
  logic [63:0] buf_data_q;
  logic        buf_vld_q;
  logic        unused;
  assign unused   = ^{ifu_ram_size_i, off[2:0]};
  // A same-cycle invalidate must not be answered from the stale entry.
  assign hit      = buf_vld_q && !inv_i && (buf_tag_q == ifu_ram_addr_i[63:3]);
  assign buf_data = buf_data_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tag_q      <= '0;
      buf_tag_q  <= '0;
      buf_data_q <= '0;
      buf_vld_q  <= 1'b0;
    end else begin
      if (accept) tag_q <= ifu_ram_addr_i[63:3];
      if (inv_i) buf_vld_q <= 1'b0;
      else if (state_q == CAP && inr_q) begin
        buf_vld_q  <= 1'b1;
        buf_tag_q  <= tag_q;
        buf_data_q <= sram_rdata_i;
      end
    end
`else
  logic unused;
  assign unused   = ^{ifu_ram_size_i, off[2:0], inv_i};
  assign hit      = 1'b0;
  assign buf_data = '0;
`endif
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    inr_d   = inr_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (ifu_ram_cen_i) begin
        idx_d = off[DEPTH_LOG2+2:3];
        inr_d = in_range;
        if (hit) begin
          state_d = RSP;
          data_d  = buf_data;
          err_d   = 1'b0;
        end else begin
          // Out-of-range requests still spend a cycle in RD (SRAM left idle)
          // so both kinds of request see identical latency.
          state_d = RD;
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        data_d  = inr_q ? sram_rdata_i : 64'h0;
        err_d   = ~inr_q;
        state_d = (WAIT_CYCLES > 0) ? WT : RSP;
      end
      WT: begin
        cnt_d = cnt_q + 4'd1;
        if ({1'b0, cnt_q} + 5'd1 == 5'(WAIT_CYCLES)) begin
          cnt_d   = '0;
          state_d = RSP;
        end
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sram_cen_d = (state_d == RD) && inr_d;
    valid_d    = (state_d == RSP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      inr_q      <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      sram_cen_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      inr_q      <= inr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      sram_cen_q <= sram_cen_d;
      cnt_q      <= cnt_d;
    end
  assign ifu_ram_data_o  = data_q;
  assign ifu_ram_err_o   = err_q;
  assign ifu_ram_valid_o = valid_q;
  assign sram_cen_o      = sram_cen_q;
  assign sram_addr_o     = idx_q;
endmodule

// File: tb/tb_ifu_ram_resp.sv
// tb_ifu_ram_resp: scoreboard bench for ifu_ram_resp (zero and three wait states)
module tb_ifu_ram_resp;
  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          DL2   = 16;
  localparam logic [63:0] LIMIT = BASE + (64'd8 << DL2);
`ifdef IRAM_LINE_BUF_EN
  localparam int HIT_LAT = 1;
  localparam int HIT_NC  = 0;
`else
  localparam int HIT_LAT = 3;
  localparam int HIT_NC  = 1;
`endif
  typedef struct packed {logic [63:0] d; logic e;} exp_t;
  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;
  logic cen0 = 0, cen3 = 0, inv = 0;
  logic [63:0] addr0 = 0, addr3 = 0, rdata0 = 0, rdata3 = 0;
  logic [63:0] data0, data3;
  logic valid0, valid3, err0, err3, scen0, scen3;
  logic [DL2-1:0] saddr0, saddr3;
  logic [63:0] mem [0:255];
  exp_t sb[$];
  int checks = 0, fails = 0;

  ifu_ram_resp #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ifu_ram_cen_i(cen0), .ifu_ram_addr_i(addr0),
    .ifu_ram_size_i(3'b011), .ifu_ram_data_o(data0), .ifu_ram_valid_o(valid0),
    .ifu_ram_err_o(err0), .inv_i(inv), .sram_cen_o(scen0), .sram_addr_o(saddr0),
    .sram_rdata_i(rdata0));
  ifu_ram_resp #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ifu_ram_cen_i(cen3), .ifu_ram_addr_i(addr3),
    .ifu_ram_size_i(3'b011), .ifu_ram_data_o(data3), .ifu_ram_valid_o(valid3),
    .ifu_ram_err_o(err3), .inv_i(inv), .sram_cen_o(scen3), .sram_addr_o(saddr3),
    .sram_rdata_i(rdata3));

  always @(posedge clk) begin
    if (scen0) rdata0 <= mem[saddr0[7:0]];
    if (scen3) rdata3 <= mem[saddr3[7:0]];
  end

  function automatic exp_t model(input logic [63:0] a);
    logic [63:0] w;
    w = a - BASE;
    if (a >= BASE && a < LIMIT) return {mem[w[10:3]], 1'b0};
    return {64'h0, 1'b1};
  endfunction

  task automatic send(input bit use3, input logic [63:0] a, input bit push);
    @(posedge clk); #1;
    if (use3) begin cen3 = 1; addr3 = a; end else begin cen0 = 1; addr0 = a; end
    if (push) sb.push_back(model(a));
    @(posedge clk); #1;
    if (use3) begin cen3 = 0; addr3 = 64'hDEAD_BEEF_0000_0000; end
    else begin cen0 = 0; addr0 = 64'hDEAD_BEEF_0000_0000; end
  endtask

  // Watches a DUT for ncyc cycles, recording the first valid/sram_cen cycle,
  // their counts, the SRAM index and the response payload.
  task automatic observe(input bit use3, input int ncyc, output int fv, output int nv,
                         output int fc, output int nc, output logic [DL2-1:0] sa,
                         output logic [63:0] d, output logic e);
    fv = -1; nv = 0; fc = -1; nc = 0; sa = '0; d = '0; e = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (use3 ? valid3 : valid0) begin
        if (fv < 0) begin fv = k; d = use3 ? data3 : data0; e = use3 ? err3 : err0; end
        nv++;
      end
      if (use3 ? scen3 : scen0) begin
        if (fc < 0) begin fc = k; sa = use3 ? saddr3 : saddr0; end
        nc++;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid0 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid0); end
    checks++; if (err0 !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err0); end
    checks++; if (data0 !== 64'h0) begin fails++; $display("FAIL reset_data: got %h want 0", data0); end
    checks++; if (scen0 !== 1'b0) begin fails++; $display("FAIL reset_sram_cen: got %b want 0", scen0); end
    checks++; if (valid3 !== 1'b0) begin fails++; $display("FAIL reset_valid3: got %b want 0", valid3); end
    rst_n = 1;
  endtask

  task automatic test_basic();
    int fv, nv, fc, nc; logic [DL2-1:0] sa; logic [63:0] d; logic e; exp_t x;
    send(0, BASE, 1);
    observe(0, 6, fv, nv, fc, nc, sa, d, e);
    x = sb.pop_front();
    checks++; if (fc !== 1 || nc !== 1) begin fails++; $display("FAIL basic_sram_cen: got cycle %0d count %0d want cycle 1 count 1", fc, nc); end
    checks++; if (sa !== '0) begin fails++; $display("FAIL basic_sram_addr: got %h want 0", sa); end
    checks++; if (fv !== 3 || nv !== 1) begin fails++; $display("FAIL basic_valid: got cycle %0d count %0d want cycle 3 count 1", fv, nv); end
    checks++; if (d !== x.d || e !== x.e) begin fails++; $display("FAIL basic_data: got %h/%b want %h/%b", d, e, x.d, x.e); end
    checks++; if (data0 !== x.d) begin fails++; $display("FAIL basic_data_hold: got %h want %h", data0, x.d); end
  endtask

  task automatic test_offset();
    int fv, nv, fc, nc; logic [DL2-1:0] sa; logic [63:0] d; logic e; exp_t x;
    send(0, BASE + 64'hC, 1);
    observe(0, 6, fv, nv, fc, nc, sa, d, e);
    x = sb.pop_front();
    checks++; if (sa !== DL2'(1) || nc !== 1) begin fails++; $display("FAIL offset_sram_addr: got %h count %0d want 1 count 1", sa, nc); end
    checks++; if (fv !== 3) begin fails++; $display("FAIL offset_latency: got %0d want 3", fv); end
    checks++; if (d !== x.d || e !== x.e) begin fails++; $display("FAIL offset_data: got %h/%b want %h/%b", d, e, x.d, x.e); end
  endtask

  task automatic test_wait();
    int fv, nv, fc, nc; logic [DL2-1:0] sa; logic [63:0] d; logic e; exp_t x;
    send(1, BASE + 64'h10, 1);
    fork
      observe(1, 10, fv, nv, fc, nc, sa, d, e);
      begin
        cen3 = 1; addr3 = BASE + 64'h8;
        repeat (6) @(posedge clk);
        #1 cen3 = 0;
      end
    join
    x = sb.pop_front();
    checks++; if (fv !== 6 || nv !== 1) begin fails++; $display("FAIL wait_valid: got cycle %0d count %0d want cycle 6 count 1", fv, nv); end
    checks++; if (fc !== 1 || nc !== 1) begin fails++; $display("FAIL wait_sram_cen: got cycle %0d count %0d want cycle 1 count 1", fc, nc); end
    checks++; if (d !== x.d || e !== x.e) begin fails++; $display("FAIL wait_data: got %h/%b want %h/%b", d, e, x.d, x.e); end
  endtask

  task automatic test_out_of_range();
    logic [63:0] addrs [2];
    int fv, nv, fc, nc; logic [DL2-1:0] sa; logic [63:0] d; logic e; exp_t x;
    addrs[0] = 64'h7FFF_FFF8; addrs[1] = LIMIT;
    for (int i = 0; i < 2; i++) begin
      send(0, addrs[i], 1);
      observe(0, 6, fv, nv, fc, nc, sa, d, e);
      x = sb.pop_front();
      checks++; if (nc !== 0) begin fails++; $display("FAIL oor_sram_cen[%0d]: got %0d want 0", i, nc); end
      checks++; if (fv !== 3 || nv !== 1) begin fails++; $display("FAIL oor_valid[%0d]: got cycle %0d count %0d want cycle 3 count 1", i, fv, nv); end
      checks++; if (d !== x.d || e !== x.e) begin fails++; $display("FAIL oor_resp[%0d]: got %h/%b want %h/%b", i, d, e, x.d, x.e); end
    end
  endtask

  task automatic test_reset_mid();
    int fv, nv, fc, nc; logic [DL2-1:0] sa; logic [63:0] d; logic e; exp_t x;
    send(0, BASE + 64'h10, 1);
    observe(0, 6, fv, nv, fc, nc, sa, d, e);
    x = sb.pop_front();
    checks++; if (d !== x.d || fv !== 3) begin fails++; $display("FAIL rstmid_pre: got %h at %0d want %h at 3", d, fv, x.d); end
    send(0, BASE + 64'h18, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 0;
    #1;
    checks++; if (valid0 !== 0 || err0 !== 0 || data0 !== 64'h0 || scen0 !== 0) begin
      fails++; $display("FAIL rstmid_cap: got v%b e%b d%h c%b want all 0", valid0, err0, data0, scen0); end
    @(posedge clk); #1 rst_n = 1;
    observe(0, 6, fv, nv, fc, nc, sa, d, e);
    checks++; if (nv !== 0 || nc !== 0) begin fails++; $display("FAIL rstmid_aborted: got %0d valids %0d reads want 0 0", nv, nc); end
    send(0, BASE + 64'h18, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++; if (scen0 !== 0) begin fails++; $display("FAIL rstmid_rd: got sram_cen %b want 0", scen0); end
    @(posedge clk); #1 rst_n = 1;
    send(0, BASE, 1);
    observe(0, 6, fv, nv, fc, nc, sa, d, e);
    x = sb.pop_front();
    checks++; if (fv !== 3 || nv !== 1 || nc !== 1) begin fails++; $display("FAIL rstmid_next: got cycle %0d valids %0d reads %0d want 3 1 1", fv, nv, nc); end
    checks++; if (d !== x.d || e !== x.e) begin fails++; $display("FAIL rstmid_next_data: got %h/%b want %h/%b", d, e, x.d, x.e); end
  endtask

  task automatic test_line_buf();
    int fv, nv, fc, nc; logic [DL2-1:0] sa; logic [63:0] d; logic e; exp_t x;
    @(posedge clk); #1 inv = 1;
    @(posedge clk); #1 inv = 0;
    send(0, BASE, 1);
    observe(0, 6, fv, nv, fc, nc, sa, d, e);
    x = sb.pop_front();
    checks++; if (fv !== 3 || nc !== 1 || d !== x.d) begin fails++; $display("FAIL lbuf_fill: got cycle %0d reads %0d data %h want 3 1 %h", fv, nc, d, x.d); end
    send(0, BASE + 64'h4, 1);
    observe(0, 6, fv, nv, fc, nc, sa, d, e);
    x = sb.pop_front();
    checks++; if (fv !== HIT_LAT || nv !== 1) begin fails++; $display("FAIL lbuf_hit_latency: got cycle %0d count %0d want cycle %0d count 1", fv, nv, HIT_LAT); end
    checks++; if (nc !== HIT_NC) begin fails++; $display("FAIL lbuf_hit_reads: got %0d want %0d", nc, HIT_NC); end
    checks++; if (d !== x.d || e !== x.e) begin fails++; $display("FAIL lbuf_hit_data: got %h/%b want %h/%b", d, e, x.d, x.e); end
    @(posedge clk); #1 inv = 1;
    @(posedge clk); #1 inv = 0;
    send(0, BASE + 64'h4, 1);
    observe(0, 6, fv, nv, fc, nc, sa, d, e);
    x = sb.pop_front();
    checks++; if (fv !== 3 || nc !== 1) begin fails++; $display("FAIL lbuf_after_inv: got cycle %0d reads %0d want 3 1", fv, nc); end
    checks++; if (d !== x.d) begin fails++; $display("FAIL lbuf_after_inv_data: got %h want %h", d, x.d); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {32'hC0DE_0000 + 32'(i), 32'(i) * 32'h0101_0101};
    mem[0] = 64'h1111_2222_3333_4444;
    mem[1] = 64'hAAAA_BBBB_CCCC_DDDD;
    mem[2] = 64'h0123_4567_89AB_CDEF;
    test_reset();
    test_basic();
    test_offset();
    test_wait();
    test_out_of_range();
    test_reset_mid();
    test_line_buf();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end
endmodule
